arb_mux_nx1: RTL and testbench
==============================

// Module: arb_mux_nx1
// PURPOSE
//   Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready
//   handshake and built-in arbitration; successor to the 2:1 16-bit mux.
//   Merges several producer streams (e.g. writeback/forwarding sources) onto
//   one registered consumer port. Selection is fixed-priority, round-robin or
//   software-forced.
// PARAMETERS
//   WIDTH  16  data width per channel
//   N      4   number of input channels (2..16)
//   MODE   1   0 = fixed priority (ch0 highest), 1 = round-robin
//   SELW   $clog2(N) (localparam)  width of channel index
// PORTS
//   clk        in   1         rising-edge clock
//   reset      in   1         async, active-high reset
//   in_valid   in   N         channel i offers data
//   in_data    in   N*WIDTH   channel i data in bits [i*WIDTH +: WIDTH]
//   in_ready   out  N         channel i transfer accepted this cycle
//   force_en   in   1         1 = only channel force_sel may be granted
//   force_sel  in   SELW      forced channel index
//   out_valid  out  1         output register holds a word
//   out_data   out  WIDTH     registered selected data
//   out_sel    out  SELW      index of the channel that supplied out_data
//   out_ready  in   1         consumer accepts out_data this cycle
// BEHAVIOUR
//   - Reset (async, any time): out_valid=0, out_data=0, out_sel=0, RR pointer=0;
//     a word held in the register is discarded; in_ready=0 while reset is high.
//   - Load enable: can_load = !out_valid | out_ready (combinational).
//   - Grant (combinational, one-hot or zero):
//       force_en=1: grant = force_sel if force_sel<N and in_valid[force_sel];
//                   if force_sel>=N, no grant.
//       MODE=0: lowest-index asserted in_valid.
//       MODE=1: first asserted in_valid scanning ptr, ptr+1, ... wrapping
//               mod N.
//   - in_ready[i] = can_load & grant[i]; in_ready is never asserted for a
//     channel with in_valid=0; at most one bit is set.
//   - Transfer on channel g (in_valid[g] & in_ready[g]) at edge k:
//     out_data=in_data[g], out_sel=g, out_valid=1 from cycle k+1 (latency 1).
//   - Output drain: out_valid & out_ready with no new transfer -> out_valid=0
//     next cycle. Drain and load in the same cycle -> new word, out_valid
//     stays 1 (full throughput, 1 word/cycle).
//   - Stall: out_valid & !out_ready -> out_data/out_sel/out_valid held
//     stable; all in_ready=0.
//   - RR pointer: updates only on a transfer, to (g+1) mod N (g=N-1 wraps
//     to 0). It is unchanged by forced grants (force_en=1) and in MODE=0.
//   - No valid input with can_load=1: register drains; pointer unchanged.
//   - Inputs need not hold data while in_ready=0. No combinational path
//     from out_ready to out_data.
// TESTING
//   (WIDTH=16, N=4 unless stated)
//   1 Reset mid-stream: out_valid=1 holding 0x00AA, assert reset
//     -> out_valid=0, out_data=0, out_sel=0 immediately; RR ptr=0.
//   2 MODE=0, in_valid=4'b1010, data ch1=25, ch3=1000, out_ready=1
//     -> cycle+1 out_data=25 out_sel=1; ch3 starved until ch1 drops.
//   3 MODE=1, all 4 valid, out_ready=1 for 8 cycles
//     -> out_sel sequence 0,1,2,3,0,1,2,3, one word per cycle.
//   4 Stall: out_valid=1 holding 1000, out_ready=0 for 3 cycles with
//     inputs valid -> out_data=1000 stable, in_ready=0000; out_ready=1
//     -> next word loads the same cycle.
//   5 force_en=1, force_sel=2, in_valid=4'b1111
//     -> only ch2 granted, RR ptr unchanged.
//     force_sel=2 with in_valid[2]=0 -> no grant, out_valid falls after
//     drain.
//   6 N=3: force_sel=3 -> no grant. MODE=1 with ptr wrap 2->0 verified
//     via out_sel 2 then 0.

Source files
------------

// File: rtl/arb_mux_nx1_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arb_mux_nx1_if : N-channel producer side plus single consumer port of arb_mux_nx1
// Rev 1.0
// ---------------------------------------------------------------------------
interface arb_mux_nx1_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               force_en;
  logic [SELW-1:0]    force_sel;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, force_en, force_sel, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, force_en, force_sel, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface
`default_nettype wire

// File: rtl/arb_mux_nx1.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arb_mux_nx1 : N:1 registered mux with fixed-priority / round-robin / forced grant
// Rev 1.0
// ---------------------------------------------------------------------------
module arb_mux_nx1 #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int MODE  = 1
) (
  input  logic         clk,
  input  logic         reset,
  arb_mux_nx1_if.slave bus
);
  localparam int SELW = $clog2(N);
  localparam int NP   = 1 << SELW;

  logic             can_load;
  logic             load;
  logic [N-1:0]     hi_mask;
  logic [N-1:0]     rr_gnt;
  logic [N-1:0]     fp_gnt;
  logic [N-1:0]     force_gnt;
  logic [NP-1:0]    force_oh;
  logic [N-1:0]     gnt;
  logic [N-1:0]     ready;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  function automatic logic [N-1:0] f_lowest(input logic [N-1:0] v);
    return v & (~v + {{(N-1){1'b0}}, 1'b1});
  endfunction

  assign can_load = !out_valid_q || bus.out_ready;

  // Round-robin: prefer requesters at or above the pointer, else wrap to the lowest.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (i >= int'(ptr_q));
    end
    if ((bus.in_valid & hi_mask) != '0) begin
      rr_gnt = f_lowest(bus.in_valid & hi_mask);
    end else begin
      rr_gnt = f_lowest(bus.in_valid);
    end
  end

  assign fp_gnt = f_lowest(bus.in_valid);

  // Out-of-range force_sel shifts past bit N-1, leaving no grant.
  assign force_oh  = NP'(1) << bus.force_sel;
  assign force_gnt = force_oh[N-1:0] & bus.in_valid;

  always_comb begin
    gnt = '0;
    if (bus.force_en) begin
      gnt = force_gnt;
    end else if (MODE == 0) begin
      gnt = fp_gnt;
    end else begin
      gnt = rr_gnt;
    end
  end

  assign ready        = (can_load && !reset) ? gnt : '0;
  assign load         = |ready;
  assign bus.in_ready = ready;

  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        gnt_idx  = SELW'(i);
        gnt_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_sel_d   = gnt_idx;
      if (MODE == 1 && !bus.force_en) begin
        ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(ready));
  a_ready_has_valid: assert property (@(posedge clk) disable iff (reset)
    (ready & ~bus.in_valid) == '0);
  a_stall_holds: assert property (@(posedge clk) disable iff (reset)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_sel_q)));

endmodule
`default_nettype wire

// File: tb/tb_arb_mux_nx1.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_arb_mux_nx1 : directed checks on fixed-priority, round-robin (N=4, N=3) instances
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_arb_mux_nx1;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  arb_mux_nx1_if #(.WIDTH(16), .N(4)) if0 ();
  arb_mux_nx1_if #(.WIDTH(16), .N(4)) if1 ();
  arb_mux_nx1_if #(.WIDTH(16), .N(3)) if2 ();

  arb_mux_nx1 #(.WIDTH(16), .N(4), .MODE(0)) u_fp   (.clk(clk), .reset(reset), .bus(if0));
  arb_mux_nx1 #(.WIDTH(16), .N(4), .MODE(1)) u_rr   (.clk(clk), .reset(reset), .bus(if1));
  arb_mux_nx1 #(.WIDTH(16), .N(3), .MODE(1)) u_rr3  (.clk(clk), .reset(reset), .bus(if2));

  task automatic t_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if0.in_valid = '0; if0.in_data = '0; if0.force_en = 1'b0; if0.force_sel = '0; if0.out_ready = 1'b0;
    if1.in_valid = '0; if1.in_data = '0; if1.force_en = 1'b0; if1.force_sel = '0; if1.out_ready = 1'b0;
    if2.in_valid = '0; if2.in_data = '0; if2.force_en = 1'b0; if2.force_sel = '0; if2.out_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    step();
    step();
    reset = 1'b0;
    t_check("rst_valid", 32'(if0.out_valid), 32'd0);
    t_check("rst_data",  32'(if0.out_data),  32'd0);
    t_check("rst_sel",   32'(if0.out_sel),   32'd0);

    // Reset mid-stream: hold 0x00AA in u_fp, move u_rr pointer away from 0
    if0.in_valid = 4'b0001; if0.in_data = {16'd0, 16'd0, 16'd0, 16'h00AA}; if0.out_ready = 1'b0;
    if1.in_valid = 4'b0010; if1.in_data = {16'd0, 16'd0, 16'h0011, 16'd0}; if1.out_ready = 1'b1;
    #1;
    t_check("t1_rdy_pre", 32'(if0.in_ready), 32'h1);
    step();
    t_check("t1_valid",   32'(if0.out_valid), 32'd1);
    t_check("t1_data",    32'(if0.out_data),  32'h00AA);
    t_check("t1_rr_sel",  32'(if1.out_sel),   32'd1);
    t_check("t1_stall_rdy", 32'(if0.in_ready), 32'h0);
    if1.in_valid = '0;
    #1;
    reset = 1'b1;
    #1;
    t_check("t1_rst_valid", 32'(if0.out_valid), 32'd0);
    t_check("t1_rst_data",  32'(if0.out_data),  32'd0);
    t_check("t1_rst_sel",   32'(if0.out_sel),   32'd0);
    t_check("t1_rst_rdy",   32'(if0.in_ready),  32'h0);
    t_check("t1_rst_rrv",   32'(if1.out_valid), 32'd0);
    step();
    reset = 1'b0;
    clear_inputs();
    step();

    // Round-robin over all four channels; first grant shows pointer was reset
    if1.in_valid = 4'b1111;
    if1.in_data  = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    if1.out_ready = 1'b1;
    #1;
    t_check("t3_rdy_first", 32'(if1.in_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      step();
      t_check("t3_valid", 32'(if1.out_valid), 32'd1);
      t_check("t3_sel",   32'(if1.out_sel),   32'(k % 4));
      t_check("t3_data",  32'(if1.out_data),  32'h100 + 32'(k % 4));
    end
    if1.in_valid = '0;
    step();
    t_check("t3_drain", 32'(if1.out_valid), 32'd0);

    // Fixed priority: ch1 beats ch3 until it drops
    if0.in_valid = 4'b1010;
    if0.in_data  = {16'd1000, 16'd0, 16'd25, 16'd0};
    if0.out_ready = 1'b1;
    #1;
    t_check("t2_rdy", 32'(if0.in_ready), 32'b0010);
    step();
    t_check("t2_data", 32'(if0.out_data), 32'd25);
    t_check("t2_sel",  32'(if0.out_sel),  32'd1);
    t_check("t2_starve_rdy", 32'(if0.in_ready), 32'b0010);
    step();
    if0.in_valid = 4'b1000;
    #1;
    t_check("t2_ch3_rdy", 32'(if0.in_ready), 32'b1000);
    step();
    t_check("t2_ch3_data", 32'(if0.out_data), 32'd1000);
    t_check("t2_ch3_sel",  32'(if0.out_sel),  32'd3);

    // Stall holds 1000 with inputs pending, then release loads the same cycle
    if0.out_ready = 1'b0;
    if0.in_valid  = 4'b1010;
    if0.in_data   = {16'd1000, 16'd0, 16'd77, 16'd0};
    for (int k = 0; k < 3; k++) begin
      #1;
      t_check("t4_stall_rdy", 32'(if0.in_ready), 32'h0);
      step();
      t_check("t4_hold_data",  32'(if0.out_data),  32'd1000);
      t_check("t4_hold_valid", 32'(if0.out_valid), 32'd1);
    end
    if0.out_ready = 1'b1;
    #1;
    t_check("t4_release_rdy", 32'(if0.in_ready), 32'b0010);
    step();
    t_check("t4_new_data", 32'(if0.out_data), 32'd77);
    t_check("t4_new_sel",  32'(if0.out_sel),  32'd1);

    // Forced grant on ch2; pointer (0 after eight RR loads) must not move
    if1.force_en  = 1'b1;
    if1.force_sel = 2'd2;
    if1.in_valid  = 4'b1111;
    #1;
    t_check("t5_force_rdy", 32'(if1.in_ready), 32'b0100);
    step();
    t_check("t5_force_sel", 32'(if1.out_sel),  32'd2);
    t_check("t5_force_data", 32'(if1.out_data), 32'h0102);
    step();
    t_check("t5_force_sel2", 32'(if1.out_sel), 32'd2);
    if1.force_en = 1'b0;
    #1;
    t_check("t5_ptr_kept", 32'(if1.in_ready), 32'b0001);
    step();
    t_check("t5_rr_sel", 32'(if1.out_sel), 32'd0);
    if1.force_en = 1'b1;
    if1.in_valid = 4'b1011;
    #1;
    t_check("t5_nogrant_rdy", 32'(if1.in_ready), 32'h0);
    step();
    t_check("t5_drained", 32'(if1.out_valid), 32'd0);

    // N=3: out-of-range force, then round-robin wrap 2 -> 0
    if2.force_en  = 1'b1;
    if2.force_sel = 2'd3;
    if2.in_valid  = 3'b111;
    if2.in_data   = {16'h000C, 16'h000B, 16'h000A};
    if2.out_ready = 1'b1;
    #1;
    t_check("t6_oob_rdy", 32'(if2.in_ready), 32'h0);
    step();
    t_check("t6_oob_valid", 32'(if2.out_valid), 32'd0);
    if2.force_en = 1'b0;
    #1;
    t_check("t6_rdy_first", 32'(if2.in_ready), 32'b001);
    for (int k = 0; k < 4; k++) begin
      step();
      t_check("t6_sel",  32'(if2.out_sel),  32'(k % 3));
      t_check("t6_data", 32'(if2.out_data), 32'h0A + 32'(k % 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
